// File: rtl/seq_calc_core.sv
// Multi-cycle arithmetic core: add, subtract, shift-add multiply and restoring
// divide on two unsigned WIDTH-bit operands, with a start/busy/done handshake.
module seq_calc_core #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    CALC
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic               last_step;

  assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign sub_diff = {1'b0, a_q} - {1'b0, b_q};

  // Multiply: acc holds {partial product, remaining multiplier bits}; add the
  // multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc holds {remainder, dividend/quotient}; shift left one bit, trial
  // subtract the divisor and keep the difference only when it did not go negative.
  assign div_rem   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_rem - {1'b0, b_q};
  assign div_next  = div_trial[WIDTH]
                   ? {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0],     acc_q[WIDTH-2:0], 1'b1};

  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case statements can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          a_d     = a;
          b_d     = b;
          acc_d   = (op_e'(op) == OP_DIV) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        unique case (op_q)
          OP_ADD: begin
            out_d   = {{(WIDTH-1){1'b0}}, add_sum};
            err_d   = add_sum[WIDTH];
            done_d  = 1'b1;
            state_d = IDLE;
          end
          OP_SUB: begin
            out_d   = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
            err_d   = sub_diff[WIDTH];
            done_d  = 1'b1;
            state_d = IDLE;
          end
          OP_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
              out_d   = mul_next;
              err_d   = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
          OP_DIV: begin
            if (b_q == '0) begin
              out_d   = '1;
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              acc_d = div_next;
              cnt_d = cnt_q + CW'(1);
              if (last_step) begin
                out_d   = div_next;
                err_d   = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end
          default: ;
        endcase
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CALC);
  assign done = done_q;
  assign out  = out_q;
  assign err  = err_q;

endmodule
